stream_window_gen: RTL and testbench
====================================

Name: stream_window_gen

Overview:
- Parametrised raster-to-window generator for the corner-detection front end.
- Accepts one pixel per handshake in raster order and emits a WIN x WIN neighbourhood per accepted pixel.
- Successor to the fixed 6x6/480-column window controller. Adds parametrised geometry, ready/valid backpressure, a zero-padded border mode, start-of-frame resync, and coordinate/end-of-frame tagging.
- Sits between the pixel source and the gradient/response pipeline.

Parameters:
DATA_W  8    pixel width in bits
IMG_W   480  pixels per line (>= WIN)
IMG_H   480  lines per frame (>= WIN)
WIN     6    window side, 2..8
MODE    0    0 = interior only (window emitted only when fully inside image); 1 = causal zero-pad (window emitted for every pixel, out-of-image taps = 0)

Ports:
clk       in   1                  clock
reset     in   1                  synchronous, active-high reset
in_data   in   DATA_W             pixel
in_valid  in   1                  pixel valid
in_sof    in   1                  first pixel of frame, qualified by in_valid
in_ready  out  1                  block can accept pixel
out_data  out  WIN*WIN*DATA_W     window; tap (r,c) at bits [(r*WIN+c)*DATA_W +: DATA_W]; r=0 top (oldest) row, c=0 leftmost column
out_valid out  1                  window valid
out_ready in   1                  sink accepts window
out_x     out  clog2(IMG_W)       column of newest (bottom-right) tap
out_y     out  clog2(IMG_H)       line of newest tap
out_eof   out  1                  window belongs to last pixel of frame

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values: out_valid=0, out_eof=0, out_x=0, out_y=0, out_data=0, internal x=y=0, window regs=0. in_ready=1 on the first cycle after reset.
- Line buffer contents are not cleared by reset; they are masked by the row/column rules below.
- Accept: a pixel is accepted when in_valid & in_ready.
- Ready rule: in_ready = !out_valid | out_ready, combinational from registered out_valid.
- Storage: WIN-1 line buffers of IMG_W x DATA_W, written circularly (one per line, rotating), plus a WIN x WIN tap register array.
- On accept, the tap array shifts left one column. The new right column is the WIN-1 buffered pixels at column x for lines y-WIN+1..y-1, plus in_data at row WIN-1.
- Latency: exactly 1 cycle from accept to out_valid (registered output).
- Output stall: out_valid holds, and out_data/out_x/out_y/out_eof stay stable, until out_ready. There is no internal skid beyond the one output register.
- Counters: x increments per accept. At x=IMG_W-1, x wraps to 0 and y increments. At x=IMG_W-1 & y=IMG_H-1, both wrap to 0 and out_eof=1 on that window.
- Start of frame: an accepted pixel with in_sof=1 is treated as x=0, y=0 regardless of counters; the line-buffer rotation index is reset to 0. in_sof on a pixel already at (0,0) is a no-op.
- MODE 0: out_valid is set only for accepted pixels with x>=WIN-1 and y>=WIN-1. This gives (IMG_W-WIN+1)*(IMG_H-WIN+1) windows per frame. The eof window is always emitted.
- MODE 1: out_valid is set for every accepted pixel, giving IMG_W*IMG_H windows per frame.
  - Tap (r,c) is forced to 0 when y-(WIN-1-r) < 0 or x-(WIN-1-c) < 0.
  - Masking is applied at the output register, so stale buffer data and the previous line's tail never leak.
- Line changes: window columns never straddle lines. Columns from the previous line are masked to 0 in MODE 1 and never emitted in MODE 0.
- Simultaneous events:
  - Accept and output handshake in the same cycle: the output register reloads with no bubble, sustaining 1 window/clk.
  - in_valid with in_ready=0: the pixel is not consumed and the counters hold.
- Reset mid-frame: frame state is abandoned. The next accepted pixel is treated as (0,0) even without in_sof.
- Widths: counters are sized clog2 of their limits. No arithmetic is done on pixel data.

Test Plan:
- Continuous stream, MODE 0, IMG_W=8, IMG_H=6, WIN=3, pixel=y*16+x, out_ready=1 -> exactly 24 windows, first at (x=2,y=2) with taps row0={0x00,0x01,0x02}, row2={0x20,0x21,0x22}; last at (7,5), out_eof=1, taps row2={0x55,0x56,0x57}.
- Same stream, MODE 1 -> 48 windows; window (0,0) has tap (2,2)=0x00 and all other taps 0; window (1,3) has row0={0,0x10,0x11}, col0 all 0.
- out_ready toggled randomly (50%) with the MODE 0 stream -> same 24 windows, same order and contents; out_data stable while out_valid & !out_ready; no pixel lost or duplicated.
- in_sof asserted at pixel (4,2) mid-frame, MODE 0 -> counters restart; next window at pixel index 2*8+2 after the sof pixel, tagged (2,2), containing only post-sof data.
- reset pulsed for 1 cycle at pixel (5,3) -> out_valid=0 next cycle; restarted frame yields first window at (2,2) with correct values from the new frame only.
- Two back-to-back frames, no gap, MODE 1 -> 96 windows; second frame's (0,0) window is all zero except tap (2,2)=0x00, proving no stale-line leakage.

Source files
------------

// File: rtl/stream_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : stream_window_gen
// Purpose  : Raster-to-window generator for the corner-detection front end.
//            Takes one pixel per ready/valid handshake in raster order and
//            emits the WIN x WIN neighbourhood whose newest (bottom-right)
//            tap is that pixel. MODE 0 emits only windows fully inside the
//            image; MODE 1 emits a window for every pixel with out-of-image
//            taps forced to zero.
// Revision : 1.0 - parametrised successor of the fixed 6x6/480 controller
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/valid/sof   pixel stream; in_sof marks the first pixel of a frame
//   in_ready            high when the pixel can be accepted this cycle
//   out_data            window, tap (r,c) at [(r*WIN+c)*DATA_W +: DATA_W],
//                       r=0 oldest row, c=0 leftmost column
//   out_valid/ready     window handshake
//   out_x, out_y        coordinate of the newest tap
//   out_eof             window belongs to the last pixel of the frame
// ============================================================================
module stream_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 480,
  parameter int WIN    = 6,
  parameter int MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic [WIN*WIN*DATA_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(IMG_W)-1:0]  out_x,
  output logic [$clog2(IMG_H)-1:0]  out_y,
  output logic                      out_eof
);

  localparam int c_xW   = $clog2(IMG_W);
  localparam int c_yW   = $clog2(IMG_H);
  localparam int c_nBuf = WIN - 1;
  localparam int c_rotW = (c_nBuf > 1) ? $clog2(c_nBuf) : 1;
  localparam logic [c_xW-1:0] c_xLast = c_xW'(IMG_W - 1);
  localparam logic [c_yW-1:0] c_yLast = c_yW'(IMG_H - 1);

  // Frame position and line-buffer rotation
  logic [c_xW-1:0]   r_x;
  logic [c_yW-1:0]   r_y;
  logic [c_rotW-1:0] r_rot;

  // Storage: one line buffer per previous line, plus the tap array
  logic [DATA_W-1:0] r_lineBuf [c_nBuf][IMG_W];
  logic [DATA_W-1:0] r_taps    [WIN][WIN];
  logic [DATA_W-1:0] w_nextTaps[WIN][WIN];

  // Output register
  logic                      r_outValid;
  logic [WIN*WIN*DATA_W-1:0] r_outData;
  logic [c_xW-1:0]           r_outX;
  logic [c_yW-1:0]           r_outY;
  logic                      r_outEof;

  logic                      w_accept;
  logic                      w_emit;
  logic                      w_lastCol;
  logic                      w_lastRow;
  logic [c_xW-1:0]           w_ex;
  logic [c_yW-1:0]           w_ey;
  logic [c_rotW-1:0]         w_eRot;
  logic [c_rotW-1:0]         w_rotInc;
  logic [WIN*WIN*DATA_W-1:0] w_window;

  // Only one output register: a new window may enter only if the slot is
  // empty or being drained in this very cycle.
  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Effective position of the incoming pixel: in_sof forces frame origin.
  assign w_ex      = in_sof ? '0 : r_x;
  assign w_ey      = in_sof ? '0 : r_y;
  assign w_eRot    = in_sof ? '0 : r_rot;
  assign w_lastCol = (w_ex == c_xLast);
  assign w_lastRow = (w_ey == c_yLast);
  assign w_rotInc  = c_rotW'((32'(w_eRot) + 32'd1) % 32'(c_nBuf));

  assign w_emit = (MODE == 1) ||
                  ((32'(w_ex) >= 32'(WIN - 1)) && (32'(w_ey) >= 32'(WIN - 1)));

  // Shift left one column; the new right column comes from the line buffers.
  // Line y-k lives in buffer (rot-k) mod (WIN-1). For k = WIN-1 that is the
  // buffer about to be overwritten at column x, read here before the write.
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        w_nextTaps[r][c] = r_taps[r][c+1];
      end
      if (r == WIN - 1) begin
        w_nextTaps[r][WIN-1] = in_data;
      end else begin
        w_nextTaps[r][WIN-1] = r_lineBuf[c_rotW'((32'(w_eRot) + 32'(c_nBuf)
                                 - 32'(WIN - 1 - r)) % 32'(c_nBuf))][w_ex];
      end
    end
  end

  // Taps above the first line or left of column 0 hold stale buffer content
  // or the previous line's tail; zero them on the way into the output.
  always_comb begin
    w_window = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((32'(w_ey) + 32'(r) >= 32'(WIN - 1)) &&
            (32'(w_ex) + 32'(c) >= 32'(WIN - 1))) begin
          w_window[(r*WIN+c)*DATA_W +: DATA_W] = w_nextTaps[r][c];
        end
      end
    end
  end

  // Line buffers are deliberately not reset; masking hides their content.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lineBuf[w_eRot][w_ex] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_rot      <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outX     <= '0;
      r_outY     <= '0;
      r_outEof   <= 1'b0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          r_taps[r][c] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        r_taps <= w_nextTaps;
        if (w_lastCol) begin
          r_x <= '0;
          if (w_lastRow) begin
            r_y   <= '0;
            r_rot <= '0;
          end else begin
            r_y   <= w_ey + c_yW'(1);
            r_rot <= w_rotInc;
          end
        end else begin
          r_x   <= w_ex + c_xW'(1);
          r_y   <= w_ey;
          r_rot <= w_eRot;
        end
        // Accept implies the slot is free or draining now: reload, no bubble.
        r_outValid <= w_emit;
        if (w_emit) begin
          r_outData <= w_window;
          r_outX    <= w_ex;
          r_outY    <= w_ey;
          r_outEof  <= w_lastCol && w_lastRow;
        end
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_x     = r_outX;
  assign out_y     = r_outY;
  assign out_eof   = r_outEof;

endmodule
`default_nettype wire

// File: tb/tb_stream_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_window_gen
// Purpose  : Self-checking bench for stream_window_gen. Two instances
//            (MODE 0 and MODE 1) on an 8x6 image with a 3x3 window. A frame
//            model (image array + scoreboard queue) predicts every window;
//            a table of spot values pins down the documented windows.
// Revision : 1.0
// ============================================================================
module tb_stream_window_gen;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int WN = 3;
  localparam int OW = WN * WN * DW;

  typedef struct {
    logic [OW-1:0] data;
    int            x;
    int            y;
    logic          eof;
  } win_t;

  typedef struct {
    int         mode;
    int         x;
    int         y;
    int         r;
    int         c;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [DW-1:0] inData   [2];
  logic          inValid  [2];
  logic          inSof    [2];
  logic          inReady  [2];
  logic [OW-1:0] outData  [2];
  logic          outValid [2];
  logic          outReady [2];
  logic [2:0]    outX     [2];
  logic [2:0]    outY     [2];
  logic          outEof   [2];

  always #5 clk = ~clk;

  stream_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN), .MODE(0)) u_dut0 (
    .clk(clk), .reset(rst),
    .in_data(inData[0]), .in_valid(inValid[0]), .in_sof(inSof[0]), .in_ready(inReady[0]),
    .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_x(outX[0]), .out_y(outY[0]), .out_eof(outEof[0])
  );

  stream_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN), .MODE(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .in_data(inData[1]), .in_valid(inValid[1]), .in_sof(inSof[1]), .in_ready(inReady[1]),
    .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_x(outX[1]), .out_y(outY[1]), .out_eof(outEof[1])
  );

  // Reference model state
  int            mx [2];
  int            my [2];
  logic [7:0]    img [2][IH][IW];
  win_t          q0 [$];
  win_t          q1 [$];
  int            nWin [2];
  bit            held [2];
  win_t          heldW [2];
  bit            accepted [2];
  logic [OW-1:0] capWin [2][IH][IW];
  logic          capEof [2][IH][IW];
  int            nCmp = 0;
  int            nBad = 0;
  vec_t          tbl [15];

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Window for a pixel at (ex,ey): neighbourhood read from the frame image,
  // zero wherever it falls above or left of the image.
  task automatic modelAccept(input int m, input logic [7:0] d, input logic sof);
    int   ex;
    int   ey;
    win_t w;
    ex = sof ? 0 : mx[m];
    ey = sof ? 0 : my[m];
    img[m][ey][ex] = d;
    if (m == 1 || (ex >= WN - 1 && ey >= WN - 1)) begin
      w.data = '0;
      for (int r = 0; r < WN; r++) begin
        for (int c = 0; c < WN; c++) begin
          int yy;
          int xx;
          yy = ey - (WN - 1) + r;
          xx = ex - (WN - 1) + c;
          if (yy >= 0 && xx >= 0) w.data[(r*WN+c)*DW +: DW] = img[m][yy][xx];
        end
      end
      w.x   = ex;
      w.y   = ey;
      w.eof = (ex == IW - 1 && ey == IH - 1);
      if (m == 0) q0.push_back(w);
      else        q1.push_back(w);
    end
    if (ex == IW - 1) begin
      mx[m] = 0;
      my[m] = (ey == IH - 1) ? 0 : ey + 1;
    end else begin
      mx[m] = ex + 1;
      my[m] = ey;
    end
  endtask

  // Evaluate the current cycle (inputs already driven), then advance one clock.
  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      win_t e;
      int   qs;
      if (held[m]) begin
        chk("hold_valid", OW'(outValid[m]), OW'(1));
        chk("hold_data",  outData[m], heldW[m].data);
        chk("hold_x",     OW'(outX[m]), OW'(heldW[m].x));
        chk("hold_y",     OW'(outY[m]), OW'(heldW[m].y));
        chk("hold_eof",   OW'(outEof[m]), OW'(heldW[m].eof));
        held[m] = 1'b0;
      end
      if (outValid[m] && outReady[m]) begin
        qs = (m == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL extra_window dut%0d: got window at (%0d,%0d), expected none",
                   m, outX[m], outY[m]);
        end else begin
          if (m == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("win_data", outData[m], e.data);
          chk("win_x",    OW'(outX[m]), OW'(e.x));
          chk("win_y",    OW'(outY[m]), OW'(e.y));
          chk("win_eof",  OW'(outEof[m]), OW'(e.eof));
        end
        capWin[m][outY[m]][outX[m]] = outData[m];
        capEof[m][outY[m]][outX[m]] = outEof[m];
        nWin[m]++;
      end else if (outValid[m]) begin
        held[m]       = 1'b1;
        heldW[m].data = outData[m];
        heldW[m].x    = int'(outX[m]);
        heldW[m].y    = int'(outY[m]);
        heldW[m].eof  = outEof[m];
      end
      accepted[m] = 1'b0;
      if (rst) begin
        mx[m]   = 0;
        my[m]   = 0;
        held[m] = 1'b0;
        if (m == 0) q0.delete();
        else        q1.delete();
      end else if (inValid[m] && inReady[m]) begin
        accepted[m] = 1'b1;
        modelAccept(m, inData[m], inSof[m]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Feed n pixels of value base + y*16 + x, frame coordinates starting at 0,0.
  task automatic feed(input int m, input int base, input int n, input bit sofFirst,
                      input int rdyPct, input int valPct);
    int cx;
    int cy;
    cx = 0;
    cy = 0;
    for (int i = 0; i < n; i++) begin
      int tries;
      tries     = 0;
      inData[m] = 8'(base + cy * 16 + cx);
      inSof[m]  = sofFirst && (i == 0);
      do begin
        inValid[m]  = ($urandom_range(99) < valPct);
        outReady[m] = ($urandom_range(99) < rdyPct);
        step();
        tries++;
      end while (!accepted[m] && tries < 200);
      if (!accepted[m]) begin
        nCmp++;
        nBad++;
        $display("FAIL accept_timeout dut%0d: pixel %0d not accepted, expected accept within 200 cycles", m, i);
      end
      if (cx == IW - 1) begin
        cx = 0;
        cy = (cy == IH - 1) ? 0 : cy + 1;
      end else begin
        cx++;
      end
    end
    inValid[m] = 1'b0;
    inSof[m]   = 1'b0;
  endtask

  task automatic drain(input int m);
    int qs;
    inValid[0]  = 1'b0;
    inValid[1]  = 1'b0;
    outReady[m] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    qs = (m == 0) ? q0.size() : q1.size();
    chk("drain_pending", OW'(qs), OW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 2, 2, 0, 0, 8'h00};
    tbl[1]  = '{0, 2, 2, 0, 1, 8'h01};
    tbl[2]  = '{0, 2, 2, 0, 2, 8'h02};
    tbl[3]  = '{0, 2, 2, 2, 0, 8'h20};
    tbl[4]  = '{0, 2, 2, 2, 1, 8'h21};
    tbl[5]  = '{0, 2, 2, 2, 2, 8'h22};
    tbl[6]  = '{0, 7, 5, 2, 0, 8'h55};
    tbl[7]  = '{0, 7, 5, 2, 1, 8'h56};
    tbl[8]  = '{0, 7, 5, 2, 2, 8'h57};
    tbl[9]  = '{1, 1, 3, 0, 0, 8'h00};
    tbl[10] = '{1, 1, 3, 0, 1, 8'h10};
    tbl[11] = '{1, 1, 3, 0, 2, 8'h11};
    tbl[12] = '{1, 1, 3, 1, 0, 8'h00};
    tbl[13] = '{1, 1, 3, 2, 0, 8'h00};
    tbl[14] = '{1, 1, 3, 2, 2, 8'h31};

    for (int m = 0; m < 2; m++) begin
      inData[m]   = '0;
      inValid[m]  = 1'b0;
      inSof[m]    = 1'b0;
      outReady[m] = 1'b1;
      mx[m]       = 0;
      my[m]       = 0;
      nWin[m]     = 0;
      held[m]     = 1'b0;
      accepted[m] = 1'b0;
    end

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", OW'(outValid[m]), OW'(0));
      chk("rst_out_eof",   OW'(outEof[m]),   OW'(0));
      chk("rst_out_x",     OW'(outX[m]),     OW'(0));
      chk("rst_out_y",     OW'(outY[m]),     OW'(0));
      chk("rst_out_data",  outData[m],       OW'(0));
      chk("rst_in_ready",  OW'(inReady[m]),  OW'(1));
    end

    // Continuous MODE 0 frame
    nWin[0] = 0;
    feed(0, 0, IW * IH, 1'b1, 100, 100);
    drain(0);
    chk("m0_count", OW'(nWin[0]), OW'(24));
    chk("m0_eof_last", OW'(capEof[0][5][7]), OW'(1));
    chk("m0_eof_prev", OW'(capEof[0][5][6]), OW'(0));

    // Two back-to-back MODE 1 frames
    nWin[1] = 0;
    feed(1, 0, 2 * IW * IH, 1'b1, 100, 100);
    drain(1);
    chk("m1_count", OW'(nWin[1]), OW'(96));
    chk("m1_origin_window", capWin[1][0][0], OW'(0));

    for (int i = 0; i < 15; i++) begin
      logic [OW-1:0] w;
      w = capWin[tbl[i].mode][tbl[i].y][tbl[i].x];
      chk($sformatf("tap_m%0d_x%0d_y%0d_r%0d_c%0d", tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].c),
          OW'(w[(tbl[i].r*WN+tbl[i].c)*DW +: DW]), OW'(tbl[i].exp));
    end

    // Random output backpressure and input gaps, two MODE 0 frames
    nWin[0] = 0;
    feed(0, 0, 2 * IW * IH, 1'b1, 50, 80);
    drain(0);
    chk("bp_count", OW'(nWin[0]), OW'(48));

    // Mid-frame in_sof at pixel (4,2)
    nWin[0] = 0;
    feed(0, 0, 20, 1'b1, 100, 100);
    feed(0, 8'h80, IW * IH, 1'b1, 100, 100);
    drain(0);
    chk("sof_count", OW'(nWin[0]), OW'(26));
    chk("sof_tap00", OW'(capWin[0][2][2][7:0]),   OW'(8'h80));
    chk("sof_tap22", OW'(capWin[0][2][2][71:64]), OW'(8'hA2));

    // Reset pulsed after pixel (5,3)
    nWin[0] = 0;
    feed(0, 0, 30, 1'b1, 100, 100);
    outReady[0] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", OW'(outValid[0]), OW'(0));
    chk("midrst_in_ready",  OW'(inReady[0]),  OW'(1));
    feed(0, 8'h40, IW * IH, 1'b0, 100, 100);
    drain(0);
    chk("midrst_count", OW'(nWin[0]), OW'(34));
    chk("midrst_tap00", OW'(capWin[0][2][2][7:0]),   OW'(8'h40));
    chk("midrst_tap22", OW'(capWin[0][2][2][71:64]), OW'(8'h62));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
